// File: rtl/lee_pkg.sv
// Shared definitions for the Lee maze router: cell encodings,
// controller states and neighbour direction codes.
package lee_pkg;

  localparam logic [7:0] CELL_EMPTY = 8'h00;
  localparam logic [7:0] CELL_BLOCK = 8'hFF;
  localparam logic [7:0] CELL_PATH  = 8'hFE;
  localparam logic [7:0] LABEL_SRC  = 8'h01;

  typedef enum logic [4:0] {
    IDLE,
    CHK_SRC,
    CHK_DST,
    SEED,
    SCAN_RD,
    SCAN_WAIT,
    SCAN_CHK,
    NB_RD,
    NB_WAIT,
    NB_CHK,
    NB_WR,
    PASS_END,
    BT_MARK,
    BT_RD,
    BT_WAIT,
    BT_CHK,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    DIR_N = 2'd0,
    DIR_E = 2'd1,
    DIR_S = 2'd2,
    DIR_W = 2'd3
  } dir_t;

endpackage

// File: rtl/lee_nbr_addr.sv
// Neighbour address of grid cell (x,y) in direction dir; ok=0 when the
// neighbour falls off the grid, so callers never see a wrapped address.
module lee_nbr_addr
  import lee_pkg::*;
#(
  parameter int GRID_LOG2  = 3,
  parameter int ADDR_WIDTH = 8
) (
  input  logic [GRID_LOG2-1:0]  x,
  input  logic [GRID_LOG2-1:0]  y,
  input  logic [1:0]            dir,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  ok
);

  logic [GRID_LOG2-1:0] nx;
  logic [GRID_LOG2-1:0] ny;

  always_comb begin
    nx = x;
    ny = y;
    ok = 1'b0;
    unique case (dir)
      DIR_N: begin
        ok = (y != '0);
        ny = y - 1'b1;
      end
      DIR_E: begin
        ok = (x != '1);
        nx = x + 1'b1;
      end
      DIR_S: begin
        ok = (y != '1);
        ny = y + 1'b1;
      end
      DIR_W: begin
        ok = (x != '0);
        nx = x - 1'b1;
      end
      default: ok = 1'b0;
    endcase
    addr = ADDR_WIDTH'({ny, nx});
  end

endmodule

// File: rtl/lee_wave_router.sv
// Lee wavefront fill plus backtrace over an 8x8 grid in a synchronous
// SRAM with one read wait state; sole master of that SRAM.
module lee_wave_router
  import lee_pkg::*;
#(
  parameter int         DATA_WIDTH = 8,
  parameter int         ADDR_WIDTH = 8,
  parameter int         GRID_LOG2  = 3,
  parameter logic [7:0] MAX_LABEL  = 8'hFD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [GRID_LOG2-1:0]  src_x,
  input  logic [GRID_LOG2-1:0]  src_y,
  input  logic [GRID_LOG2-1:0]  dst_x,
  input  logic [GRID_LOG2-1:0]  dst_y,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_cs,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  found
);

  typedef logic [GRID_LOG2-1:0] crd_t;

  state_t                state;
  dir_t                  dir;
  crd_t                  sx, sy, dx, dy;
  crd_t                  cx, cy;
  logic [DATA_WIDTH-1:0] k;
  logic [DATA_WIDTH-1:0] lbl;
  logic                  ph;
  logic                  prog;

  logic [ADDR_WIDTH-1:0] nb_addr;
  logic                  nb_ok;
  logic                  last_dir;
  logic                  last_cell;
  logic                  nb_is_dst;
  crd_t                  nb_x, nb_y;
  state_t                nb_step;

  function automatic logic [ADDR_WIDTH-1:0] at(input crd_t x, input crd_t y);
    return ADDR_WIDTH'({y, x});
  endfunction

  lee_nbr_addr #(
    .GRID_LOG2 (GRID_LOG2),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_nbr (
    .x   (cx),
    .y   (cy),
    .dir (dir),
    .addr(nb_addr),
    .ok  (nb_ok)
  );

  assign last_dir  = (dir == DIR_W);
  assign last_cell = &{cy, cx};
  assign nb_is_dst = (nb_addr == at(dx, dy));
  assign nb_x      = nb_addr[GRID_LOG2-1:0];
  assign nb_y      = nb_addr[2*GRID_LOG2-1:GRID_LOG2];

  // Where the neighbour loop goes once the current direction is finished
  always_comb begin
    nb_step = NB_RD;
    if (last_dir) nb_step = last_cell ? PASS_END : SCAN_RD;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dir       <= DIR_N;
      sx        <= '0;
      sy        <= '0;
      dx        <= '0;
      dy        <= '0;
      cx        <= '0;
      cy        <= '0;
      k         <= '0;
      lbl       <= '0;
      ph        <= 1'b0;
      prog      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_cs    <= 1'b0;
      mem_we    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      found     <= 1'b0;
    end else begin
      mem_cs <= 1'b0;
      mem_we <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            sx       <= src_x;
            sy       <= src_y;
            dx       <= dst_x;
            dy       <= dst_y;
            done     <= 1'b0;
            found    <= 1'b0;
            busy     <= 1'b1;
            ph       <= 1'b0;
            mem_cs   <= 1'b1;
            mem_addr <= at(src_x, src_y);
            state    <= CHK_SRC;
          end
        end
        CHK_SRC: begin
          if (!ph) begin
            ph <= 1'b1;
          end else if (mem_rdata != CELL_EMPTY) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            ph       <= 1'b0;
            mem_cs   <= 1'b1;
            mem_addr <= at(dx, dy);
            state    <= CHK_DST;
          end
        end
        CHK_DST: begin
          if (!ph) begin
            ph <= 1'b1;
          end else if (mem_rdata != CELL_EMPTY) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            mem_cs    <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= at(sx, sy);
            mem_wdata <= LABEL_SRC;
            state     <= SEED;
          end
        end
        SEED: begin
          k    <= LABEL_SRC;
          prog <= 1'b0;
          if (sx == dx && sy == dy) begin
            cx        <= sx;
            cy        <= sy;
            lbl       <= LABEL_SRC;
            mem_cs    <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= at(sx, sy);
            mem_wdata <= CELL_PATH;
            state     <= BT_MARK;
          end else begin
            cx    <= '0;
            cy    <= '0;
            state <= SCAN_RD;
          end
        end
        SCAN_RD: begin
          mem_cs   <= 1'b1;
          mem_addr <= at(cx, cy);
          state    <= SCAN_WAIT;
        end
        SCAN_WAIT: state <= SCAN_CHK;
        SCAN_CHK: begin
          if (mem_rdata == k) begin
            dir   <= DIR_N;
            state <= NB_RD;
          end else begin
            {cy, cx} <= {cy, cx} + 1'b1;
            state    <= last_cell ? PASS_END : SCAN_RD;
          end
        end
        NB_RD: begin
          if (nb_ok) begin
            mem_cs   <= 1'b1;
            mem_addr <= nb_addr;
            state    <= NB_WAIT;
          end else begin
            if (last_dir) {cy, cx} <= {cy, cx} + 1'b1;
            else dir <= dir_t'(dir + 2'd1);
            state <= nb_step;
          end
        end
        NB_WAIT: state <= NB_CHK;
        NB_CHK: begin
          if (mem_rdata == CELL_EMPTY) begin
            mem_cs    <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= nb_addr;
            mem_wdata <= k + 1'b1;
            prog      <= 1'b1;
            state     <= NB_WR;
          end else begin
            if (last_dir) {cy, cx} <= {cy, cx} + 1'b1;
            else dir <= dir_t'(dir + 2'd1);
            state <= nb_step;
          end
        end
        NB_WR: begin
          if (nb_is_dst) begin
            cx        <= dx;
            cy        <= dy;
            lbl       <= k + 1'b1;
            mem_cs    <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= nb_addr;
            mem_wdata <= CELL_PATH;
            state     <= BT_MARK;
          end else begin
            if (last_dir) {cy, cx} <= {cy, cx} + 1'b1;
            else dir <= dir_t'(dir + 2'd1);
            state <= nb_step;
          end
        end
        PASS_END: begin
          if (!prog || k == MAX_LABEL) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            k     <= k + 1'b1;
            prog  <= 1'b0;
            cx    <= '0;
            cy    <= '0;
            state <= SCAN_RD;
          end
        end
        BT_MARK: begin
          if (lbl == LABEL_SRC) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            found <= 1'b1;
            state <= DONE;
          end else begin
            dir   <= DIR_N;
            state <= BT_RD;
          end
        end
        BT_RD: begin
          if (nb_ok) begin
            mem_cs   <= 1'b1;
            mem_addr <= nb_addr;
            state    <= BT_WAIT;
          end else if (last_dir) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            dir <= dir_t'(dir + 2'd1);
          end
        end
        BT_WAIT: state <= BT_CHK;
        BT_CHK: begin
          if (mem_rdata == lbl - 1'b1) begin
            cx        <= nb_x;
            cy        <= nb_y;
            lbl       <= lbl - 1'b1;
            mem_cs    <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= nb_addr;
            mem_wdata <= CELL_PATH;
            state     <= BT_MARK;
          end else if (last_dir) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            dir   <= dir_t'(dir + 2'd1);
            state <= BT_RD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lee_wave_router.sv
// Directed bench for lee_wave_router with a behavioural one-wait-state
// SRAM and a queue of expected results checked as each run completes.
module tb_lee_wave_router;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] src_x, src_y, dst_x, dst_y;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_cs, mem_we;
  logic       busy, done, found;

  always #5 clk = ~clk;

  lee_wave_router dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .src_x    (src_x),
    .src_y    (src_y),
    .dst_x    (dst_x),
    .dst_y    (dst_y),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_cs   (mem_cs),
    .mem_we   (mem_we),
    .mem_rdata(mem_rdata),
    .busy     (busy),
    .done     (done),
    .found    (found)
  );

  logic [7:0] mem[64];
  logic [7:0] img[64];
  logic       load = 1'b0;
  int         wr_cnt;
  logic [7:0] wa[4];
  logic [7:0] wd[4];
  logic [7:0] lbl63;

  // SRAM model plus a write monitor; load copies img in and clears the log
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 64; i++) mem[i] <= img[i];
      wr_cnt <= 0;
      lbl63  <= 8'h00;
    end else if (mem_cs === 1'b1) begin
      if (mem_we) begin
        mem[mem_addr[5:0]] <= mem_wdata;
        if (wr_cnt < 4) begin
          wa[wr_cnt[1:0]] <= mem_addr;
          wd[wr_cnt[1:0]] <= mem_wdata;
        end
        wr_cnt <= wr_cnt + 1;
        if (mem_addr == 8'd63 && lbl63 == 8'h00) lbl63 <= mem_wdata;
      end else begin
        mem_rdata <= mem[mem_addr[5:0]];
      end
    end
  end

  int          pass = 0;
  int          total = 0;
  logic [31:0] exp_q[$];

  task automatic expect_val(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    total++;
    if (exp_q.size() == 0) begin
      $error("FAIL %s observed=%0h expected=<none>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < 64; i++) img[i] = 8'h00;
  endtask

  task automatic load_img();
    @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic go(input int x0, input int y0, input int x1, input int y1);
    @(negedge clk);
    src_x = 3'(x0);
    src_y = 3'(y0);
    dst_x = 3'(x1);
    dst_y = 3'(y1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 20000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (done !== 1'b1) begin
      total++;
      $error("FAIL %s_timeout observed=done_low expected=done_high", tag);
    end
  endtask

  function automatic int count_fe();
    int n = 0;
    for (int i = 0; i < 64; i++) if (mem[i] == 8'hFE) n++;
    return n;
  endfunction

  function automatic int count_right();
    int n = 0;
    for (int i = 0; i < 64; i++) if (i % 8 > 3 && mem[i] != 8'h00) n++;
    return n;
  endfunction

  initial begin
    int cyc;
    rst   = 1'b1;
    start = 1'b0;
    src_x = 3'd0;
    src_y = 3'd0;
    dst_x = 3'd0;
    dst_y = 3'd0;
    clear_img();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // reset state
    expect_val(0); check("rst_busy", busy);
    expect_val(0); check("rst_done", done);
    expect_val(0); check("rst_found", found);
    expect_val(0); check("rst_cs", mem_cs);
    expect_val(0); check("rst_we", mem_we);
    expect_val(0); check("rst_addr", mem_addr);

    // open grid, corner to corner
    clear_img();
    load_img();
    expect_val(1); expect_val(1); expect_val(15);
    expect_val(8'hFE); expect_val(8'hFE); expect_val(8'h0F);
    go(0, 0, 7, 7);
    wait_done("t1", cyc);
    @(negedge clk);
    check("t1_found", found);
    check("t1_done", done);
    check("t1_fe_count", count_fe());
    check("t1_src_mark", mem[0]);
    check("t1_dst_mark", mem[63]);
    check("t1_dst_label", lbl63);

    // wall at x=3 cuts the grid in two
    clear_img();
    for (int y = 0; y < 8; y++) img[y * 8 + 3] = 8'hFF;
    load_img();
    expect_val(0); expect_val(1); expect_val(0); expect_val(1);
    go(0, 0, 7, 7);
    wait_done("t2", cyc);
    @(negedge clk);
    check("t2_found", found);
    check("t2_done", done);
    check("t2_right_side", count_right());
    repeat (10) @(negedge clk);
    check("t2_done_held", done);

    // blocked target aborts without writing
    clear_img();
    img[63] = 8'hFF;
    load_img();
    expect_val(0); expect_val(1); expect_val(0);
    go(0, 0, 7, 7);
    wait_done("t3", cyc);
    @(negedge clk);
    check("t3_found", found);
    check("t3_fast", 32'(cyc <= 6));
    check("t3_writes", wr_cnt);

    // source equals target
    clear_img();
    load_img();
    expect_val(2); expect_val(8'h24); expect_val(8'h01);
    expect_val(8'h24); expect_val(8'hFE); expect_val(1);
    go(4, 4, 4, 4);
    wait_done("t4", cyc);
    @(negedge clk);
    check("t4_writes", wr_cnt);
    check("t4_wr0_addr", wa[0]);
    check("t4_wr0_data", wd[0]);
    check("t4_wr1_addr", wa[1]);
    check("t4_wr1_data", wd[1]);
    check("t4_found", found);

    // reset while the k=3 pass is labelling cells
    clear_img();
    load_img();
    go(0, 0, 7, 7);
    cyc = 0;
    while (!(mem_cs === 1'b1 && mem_we === 1'b1 && mem_wdata == 8'h04) &&
           cyc < 5000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    expect_val(1);
    check("t5_reached_k3", 32'(cyc < 5000));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    expect_val(0); check("t5_cs", mem_cs);
    expect_val(0); check("t5_busy", busy);
    expect_val(0); check("t5_done", done);
    @(negedge clk);
    rst = 1'b0;
    clear_img();
    load_img();
    expect_val(1); expect_val(15); expect_val(8'h0F);
    go(0, 0, 7, 7);
    wait_done("t5", cyc);
    @(negedge clk);
    check("t5_found", found);
    check("t5_fe_count", count_fe());
    check("t5_dst_label", lbl63);

    // a second start while busy must be ignored
    clear_img();
    load_img();
    expect_val(1); expect_val(15); expect_val(8'hFE);
    expect_val(8'hFE); expect_val(8'h0F); expect_val(0);
    go(0, 0, 7, 7);
    repeat (20) @(negedge clk);
    src_x = 3'd2;
    src_y = 3'd2;
    dst_x = 3'd5;
    dst_y = 3'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t6", cyc);
    @(negedge clk);
    check("t6_found", found);
    check("t6_fe_count", count_fe());
    check("t6_src_mark", mem[0]);
    check("t6_dst_mark", mem[63]);
    check("t6_dst_label", lbl63);
    check("t6_stray_cell", mem[2 * 8 + 2] == 8'h00 ? 0 : 32'(mem[45] == 8'hFE));

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
